// File: rtl/mips_pkg.sv
// Shared register-file constants, index/word types and the per-register reset value.
package mips_pkg;

    localparam int REG_W     = 32;
    localparam int REG_CNT   = 32;
    localparam int REG_IDX_W = 5;
    localparam int SP_IDX    = 29;
    localparam int RA_IDX    = 31;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [REG_W-1:0]     word_t;

    // Only the stack pointer and return address come out of reset non-zero.
    function automatic word_t reset_value(input int idx, input word_t sp_init, input word_t ra_init);
        word_t value;
        value = '0;
        if (idx == SP_IDX) begin
            value = sp_init;
        end else if (idx == RA_IDX) begin
            value = ra_init;
        end
        return value;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file; register 0 always reads as zero.
// With REGFILE_BYPASS_EN defined, an in-flight write to the addressed register is forwarded.
module regfile_rdport
    import mips_pkg::*;
(
    input  reg_idx_t i_rd_num,
    input  word_t    i_regs [REG_CNT],
`ifdef REGFILE_BYPASS_EN
    input  logic     i_reset,
    input  logic     i_wr_en,
    input  reg_idx_t i_wr_num,
    input  word_t    i_wr_data,
`endif
    output word_t    o_rd_data
);

    word_t w_rd_data;

    always_comb begin
        w_rd_data = i_regs[i_rd_num];
`ifdef REGFILE_BYPASS_EN
        // A write blocked by reset or aimed at r0 never takes effect, so it is never forwarded.
        if (i_wr_en && !i_reset && (i_wr_num == i_rd_num)) begin
            w_rd_data = i_wr_data;
        end
`endif
        if (i_rd_num == '0) begin
            w_rd_data = '0;
        end
    end

    assign o_rd_data = w_rd_data;

endmodule

// File: rtl/regfile.sv
// 32x32 register file: one synchronous write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile
    import mips_pkg::*;
#(
    parameter word_t SP_INIT = 32'h80120000,
    parameter word_t RA_INIT = 32'h00000000
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] wr_num,
    input  logic [REG_W-1:0]     wr_data,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] rd0_num,
    output logic [REG_W-1:0]     rd0_data,
    input  logic [REG_IDX_W-1:0] rd1_num,
    output logic [REG_W-1:0]     rd1_data
);

    localparam int RD_PORTS = 2;

    word_t    r_regs    [REG_CNT];
    reg_idx_t w_rd_num  [RD_PORTS];
    word_t    w_rd_data [RD_PORTS];

    // Reset takes priority over a write on the same edge; writes to r0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= reset_value(i, SP_INIT, RA_INIT);
            end
        end else if (wr_en && (wr_num != '0)) begin
            r_regs[wr_num] <= wr_data;
        end
    end

    assign w_rd_num[0] = rd0_num;
    assign w_rd_num[1] = rd1_num;
    assign rd0_data    = w_rd_data[0];
    assign rd1_data    = w_rd_data[1];

    generate
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rdport
            regfile_rdport u_rdport (
                .i_rd_num  (w_rd_num[gi]),
                .i_regs    (r_regs),
`ifdef REGFILE_BYPASS_EN
                .i_reset   (reset),
                .i_wr_en   (wr_en),
                .i_wr_num  (wr_num),
                .i_wr_data (wr_data),
`endif
                .o_rd_data (w_rd_data[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed cases then random traffic against an array model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_num = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd0_num = '0;
    logic [4:0]  rd1_num = '0;
    logic [31:0] rd0_data;
    logic [31:0] rd1_data;

    regfile dut (
        .clk      (clk),
        .reset    (reset),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd0_num  (rd0_num),
        .rd0_data (rd0_data),
        .rd1_num  (rd1_num),
        .rd1_data (rd1_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    bit          model_ok = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Architectural view of a read: r0 is zero, otherwise the stored value (or forwarded write).
    function automatic logic [31:0] ref_read(input logic [4:0] n);
        if (n == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !reset && wr_num == n) return wr_data;
`endif
        return model[n];
    endfunction

    // Apply to the model whatever the DUT sampled on the edge just taken.
    task automatic commit_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[29] = 32'h80120000;
            model[31] = 32'h00000000;
            model_ok  = 1'b1;
        end else if (wr_en && wr_num != 5'd0) begin
            model[wr_num] = wr_data;
        end
    endtask

    task automatic drive(input bit rst, input bit we, input logic [4:0] wn, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1, input string tag);
        exp_t e;
        @(posedge clk);
        commit_edge();
        #1;
        reset   = rst;
        wr_en   = we;
        wr_num  = wn;
        wr_data = wd;
        rd0_num = r0;
        rd1_num = r1;
        if (model_ok) begin
            e.tag = tag;
            e.e0  = ref_read(r0);
            e.e1  = ref_read(r1);
            sb.push_back(e);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (rd0_data !== e.e0) begin
                    n_err++;
                    $display("FAIL %s rd0[%0d]: got %h expected %h", e.tag, rd0_num, rd0_data, e.e0);
                end
                n_cmp++;
                if (rd1_data !== e.e1) begin
                    n_err++;
                    $display("FAIL %s rd1[%0d]: got %h expected %h", e.tag, rd1_num, rd1_data, e.e1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit          rst, we;
        logic [4:0]  wn, r0, r1;
        logic [31:0] wd;

        // Reset with a competing write to r29: reset must win.
        drive(1, 1, 5'd29, 32'h1, 5'd29, 5'd31, "reset_edge");
        drive(0, 0, 5'd0, 32'h0, 5'd29, 5'd31, "reset_sp_ra");
        drive(0, 0, 5'd0, 32'h0, 5'd5, 5'd29, "reset_r5");
        // Write then read on both ports.
        drive(0, 1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8, "wr8_same_cycle");
        drive(0, 0, 5'd0, 32'h0, 5'd8, 5'd8, "wr8_read");
        // r0 is hardwired.
        drive(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd8, "wr0_same_cycle");
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, "wr0_read");
        // wr_en low leaves r4 untouched.
        drive(0, 1, 5'd4, 32'h11112222, 5'd4, 5'd0, "wr4_set");
        drive(0, 0, 5'd4, 32'hFFFFFFFF, 5'd4, 5'd4, "wr4_disabled");
        drive(0, 0, 5'd0, 32'h0, 5'd4, 5'd4, "wr4_read");
        // Same-cycle read of the register being written.
        drive(0, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, "wr3_same_cycle");
        drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd29, "wr3_read");
        // Back-to-back writes to the same index: last one wins.
        drive(0, 1, 5'd9, 32'h00000001, 5'd9, 5'd0, "wr9_first");
        drive(0, 1, 5'd9, 32'h00000002, 5'd9, 5'd9, "wr9_second");
        drive(0, 0, 5'd0, 32'h0, 5'd9, 5'd9, "wr9_read");

        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wd  = $urandom();
            r0  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
            drive(rst, we, wn, wd, r0, r1, "random");
        end

        drive(0, 0, 5'd0, 32'h0, 5'd29, 5'd31, "final");
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
